wb_memtest_multi: RTL

- Parametrised Wishbone classic-cycle master that runs write-then-verify passes over a configurable DDR window.
- Supports selectable data patterns, multiple passes, error counting and first-error capture.
- Sits between board-level status LEDs / debug registers and the DDR controller's Wishbone slave port; used for bring-up and soak testing.

---
 rtl/wb_memtest_pkg.sv | 28 ++
 rtl/wb_memtest_pattern.sv | 59 +++++
 rtl/wb_memtest_multi.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_memtest_pkg.sv
// rtl/wb_memtest_pkg.sv - shared encodings for the Wishbone memory tester
// Contents: pattern mode codes, FSM state type, Galois LFSR tap masks.
package wb_memtest_pkg;

    localparam logic [1:0] MODE_ADDR  = 2'd0;
    localparam logic [1:0] MODE_NADDR = 2'd1;
    localparam logic [1:0] MODE_LFSR  = 2'd2;
    localparam logic [1:0] MODE_WALK  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_WAIT,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_PASS_END,
        ST_DONE
    } state_t;

    // Right-shifting Galois masks: x^32+x^22+x^2+x+1 and x^64+x^63+x^61+x^60+1
    localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;
    localparam logic [63:0] LFSR_TAPS_64 = 64'hD800_0000_0000_0000;

    function automatic logic [63:0] lfsr_taps(input int width);
        return (width == 64) ? LFSR_TAPS_64 : {32'd0, LFSR_TAPS_32};
    endfunction

endpackage

// File: rtl/wb_memtest_pattern.sv
// rtl/wb_memtest_pattern.sv - per-word test pattern generator, owns the LFSR
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   mode             pattern select (MODE_ADDR/NADDR/LFSR/WALK)
//   index            word index within the pass
//   address          byte address of the current word
//   load             restart the LFSR from LFSR_SEED
//   step             advance the LFSR by one word
//   pattern          data for the current word
module wb_memtest_pattern
    import wb_memtest_pkg::*;
#(
    parameter int                ADR_W     = 32,
    parameter int                DAT_W     = 32,
    parameter int                IDX_W     = 8,
    parameter logic [DAT_W-1:0]  LFSR_SEED = DAT_W'(32'hACE1_2468)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           mode,
    input  logic [IDX_W-1:0]     index,
    input  logic [ADR_W-1:0]     address,
    input  logic                 load,
    input  logic                 step,
    output logic [DAT_W-1:0]     pattern
);

    localparam logic [DAT_W-1:0] TAPS = DAT_W'(lfsr_taps(DAT_W));

    logic [DAT_W-1:0] lfsr;
    logic [DAT_W-1:0] adr_ext;
    logic [DAT_W-1:0] walk;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr <= LFSR_SEED;
        end else if (load) begin
            lfsr <= LFSR_SEED;
        end else if (step) begin
            lfsr <= {1'b0, lfsr[DAT_W-1:1]} ^ (lfsr[0] ? TAPS : '0);
        end
    end

    // Address is zero-extended or truncated to the data width.
    assign adr_ext = DAT_W'(address);
    assign walk    = {{(DAT_W-1){1'b0}}, 1'b1} << (32'(index) % 32'(DAT_W));

    always_comb begin
        pattern = adr_ext;
        case (mode)
            MODE_ADDR:  pattern = adr_ext;
            MODE_NADDR: pattern = ~adr_ext;
            MODE_LFSR:  pattern = lfsr;
            MODE_WALK:  pattern = walk;
            default:    pattern = adr_ext;
        endcase
    end

endmodule

// File: rtl/wb_memtest_multi.sv
// rtl/wb_memtest_multi.sv - Wishbone classic master running write/verify passes
// Optional feature macro: MEMTEST_ACK_TIMEOUT_EN (ack watchdog + timeout_flag port)
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   start, stop, mode     run control and pattern select
//   busy, done            run status, one-cycle end-of-run pulse
//   pass_cnt, err_cnt     completed passes, read mismatches (saturating)
//   err_adr/exp/got       first mismatch of the run
//   led                   status bits
//   timeout_flag          sticky ack timeout (only with MEMTEST_ACK_TIMEOUT_EN)
//   wb_*                  Wishbone classic master interface
module wb_memtest_multi
    import wb_memtest_pkg::*;
#(
    parameter int                ADR_W      = 32,
    parameter int                DAT_W      = 32,
    parameter logic [ADR_W-1:0]  BASE_ADR   = '0,
    parameter int                NUM_WORDS  = 256,
    parameter int                ADR_STRIDE = 4,
    parameter int                PASSES     = 1,
    parameter logic [DAT_W-1:0]  LFSR_SEED  = DAT_W'(32'hACE1_2468),
    parameter int                TIMEOUT    = 1023
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop,
    input  logic [1:0]           mode,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          pass_cnt,
    output logic [15:0]          err_cnt,
    output logic [ADR_W-1:0]     err_adr,
    output logic [DAT_W-1:0]     err_exp,
    output logic [DAT_W-1:0]     err_got,
    output logic [7:0]           led,
`ifdef MEMTEST_ACK_TIMEOUT_EN
    output logic                 timeout_flag,
`endif
    output logic [ADR_W-1:0]     wb_adr_o,
    output logic [DAT_W-1:0]     wb_dat_o,
    input  logic [DAT_W-1:0]     wb_dat_i,
    output logic [DAT_W/8-1:0]   wb_sel_o,
    output logic                 wb_cyc_o,
    output logic                 wb_stb_o,
    output logic                 wb_we_o,
    input  logic                 wb_ack_i
);

    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   idx;
    logic [1:0]         mode_q;
    logic               stop_req;
    logic               cap_valid;
    logic               last_ok, last_fail, any_ok;
    logic [ADR_W-1:0]   cur_adr;
    logic [DAT_W-1:0]   pat;
    logic               pat_load, pat_step;
    logic               in_wait, word_done, last_word;
    logic               rd_mismatch, timeout_hit, err_inc, run_end, start_run;

    assign cur_adr     = BASE_ADR + ADR_W'(idx) * ADR_W'(ADR_STRIDE);
    assign in_wait     = (state == ST_WR_WAIT) || (state == ST_RD_WAIT);
    assign word_done   = in_wait && (wb_ack_i || timeout_hit);
    assign last_word   = (idx == IDX_W'(NUM_WORDS - 1));
    assign rd_mismatch = (state == ST_RD_WAIT) && wb_ack_i && (wb_dat_i != pat);
    assign err_inc     = rd_mismatch || timeout_hit;
    assign start_run   = (state == ST_IDLE) && start;
    assign run_end     = stop_req ||
                         ((PASSES != 0) && (({16'd0, pass_cnt} + 32'd1) == 32'(PASSES)));

    wb_memtest_pattern #(
        .ADR_W     (ADR_W),
        .DAT_W     (DAT_W),
        .IDX_W     (IDX_W),
        .LFSR_SEED (LFSR_SEED)
    ) u_pattern (
        .clk     (clk),
        .reset   (reset),
        .mode    (mode_q),
        .index   (idx),
        .address (cur_adr),
        .load    (pat_load),
        .step    (pat_step),
        .pattern (pat)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pat_load  = 1'b0;
        pat_step  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_WR_REQ;
                    pat_load  = 1'b1;
                end
            end
            ST_WR_REQ:  state_nxt = ST_WR_WAIT;
            ST_WR_WAIT: begin
                if (word_done) begin
                    if (last_word) begin
                        state_nxt = ST_RD_REQ;
                        pat_load  = 1'b1;
                    end else begin
                        state_nxt = ST_WR_REQ;
                        pat_step  = 1'b1;
                    end
                end
            end
            ST_RD_REQ:  state_nxt = ST_RD_WAIT;
            ST_RD_WAIT: begin
                if (word_done) begin
                    if (last_word) begin
                        state_nxt = ST_PASS_END;
                    end else begin
                        state_nxt = ST_RD_REQ;
                        pat_step  = 1'b1;
                    end
                end
            end
            ST_PASS_END: begin
                if (run_end) begin
                    state_nxt = ST_DONE;
                end else begin
                    state_nxt = ST_WR_REQ;
                    pat_load  = 1'b1;
                end
            end
            ST_DONE:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Bus signals are registered: raised when leaving a REQ state and dropped on
    // the edge after ack, so cyc is high exactly while in a WAIT state and the
    // following REQ state is always an idle bus cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_adr_o <= '0;
            wb_dat_o <= '0;
        end else if ((state == ST_WR_REQ) || (state == ST_RD_REQ)) begin
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o  <= (state == ST_WR_REQ);
            wb_adr_o <= cur_adr;
            if (state == ST_WR_REQ) begin
                wb_dat_o <= pat;
            end
        end else if (word_done) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx       <= '0;
            mode_q    <= MODE_ADDR;
            stop_req  <= 1'b0;
            pass_cnt  <= '0;
            err_cnt   <= '0;
            err_adr   <= '0;
            err_exp   <= '0;
            err_got   <= '0;
            cap_valid <= 1'b0;
            last_ok   <= 1'b0;
            last_fail <= 1'b0;
            any_ok    <= 1'b0;
        end else begin
            if (pat_load) begin
                idx <= '0;
            end else if (pat_step) begin
                idx <= idx + IDX_W'(1);
            end

            if (start_run) begin
                mode_q    <= mode;
                stop_req  <= stop;
                pass_cnt  <= '0;
                err_cnt   <= '0;
                err_adr   <= '0;
                err_exp   <= '0;
                err_got   <= '0;
                cap_valid <= 1'b0;
                last_ok   <= 1'b0;
                last_fail <= 1'b0;
                any_ok    <= 1'b0;
            end else begin
                if (stop && (state != ST_IDLE)) begin
                    stop_req <= 1'b1;
                end
                if (state == ST_PASS_END) begin
                    pass_cnt <= pass_cnt + 16'd1;
                end
                if (err_inc && (err_cnt != 16'hFFFF)) begin
                    err_cnt <= err_cnt + 16'd1;
                end
                // Write timeouts count as errors but only read failures are captured.
                if ((state == ST_RD_WAIT) && err_inc && !cap_valid) begin
                    cap_valid <= 1'b1;
                    err_adr   <= cur_adr;
                    err_exp   <= pat;
                    err_got   <= timeout_hit ? '1 : wb_dat_i;
                end
                if ((state == ST_RD_WAIT) && word_done) begin
                    last_ok   <= !err_inc;
                    last_fail <= err_inc;
                    if (!err_inc) begin
                        any_ok <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef MEMTEST_ACK_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    logic [WD_W-1:0] wd_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt <= '0;
        end else if (in_wait && !word_done) begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end else begin
            wd_cnt <= '0;
        end
    end

    // Fires on the TIMEOUT-th cycle spent waiting; an ack on that cycle wins.
    assign timeout_hit = in_wait && !wb_ack_i && (wd_cnt == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout_flag <= 1'b0;
        end else if (start_run) begin
            timeout_flag <= 1'b0;
        end else if (timeout_hit) begin
            timeout_flag <= 1'b1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign timeout_hit    = 1'b0;
`endif

    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);
    assign wb_sel_o = '1;
    assign led      = {wb_cyc_o & ~wb_we_o, wb_cyc_o & wb_we_o, wb_ack_i, busy,
                       last_ok, any_ok, last_fail, (err_cnt != 16'd0)};

endmodule
